// File: rtl/grey_frame_ctrl.sv
// grey_frame_ctrl: frame sequencer in front of the greyscale converter.
// Arms on start, aligns to the next frame start, gates pixel-valid,
// tracks x/y aligned to the converter's registered output, latches the
// grey/colour mode per frame and reports frame completion.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, cont, stop   control pulses (cont sampled with start)
//   grey_mode_req       requested mode, applied at frame start
//   in_fval/lval/dval   capture stream qualifiers
//   grey_en             combinational pixel-valid to the converter
//   grey_mode           mode latched for the current frame
//   out_dval/x/y        grey_en and coordinates delayed one cycle
//   busy, frame_done    status
//   ovf_err             sticky range-drop flag
//   frame_cnt           completed frames
//
// Optional feature macro: GREY_FRAME_CNT_EN
//   defined   -> frame_cnt counts DONE cycles, wraps, reset only by rst_n
//   undefined -> frame_cnt tied to zero, no counter register
module grey_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic          stop,
    input  logic          grey_mode_req,
    input  logic          in_fval,
    input  logic          in_lval,
    input  logic          in_dval,
    output logic          grey_en,
    output logic          grey_mode,
    output logic          out_dval,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          busy,
    output logic          frame_done,
    output logic          ovf_err,
    output logic [15:0]   frame_cnt
);

    localparam logic [CW-1:0] X_LIM = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_LIM = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic          fval_d;
    logic          lval_d;
    logic          cont_r;
    logic          stop_pending;
    logic          line_has_dval;
    logic [CW-1:0] x;
    logic [CW-1:0] y;

    logic fval_rise;
    logic fval_fall;
    logic lval_fall;
    logic pix;
    logic in_act;
    logic in_range;
    logic arm_go;
    logic start_ok;

    assign fval_rise = in_fval & ~fval_d;
    assign fval_fall = ~in_fval & fval_d;
    assign lval_fall = ~in_lval & lval_d;
    assign pix       = in_dval & in_lval;
    assign in_act    = (state == ACTIVE);
    assign in_range  = (x < X_LIM) && (y < Y_LIM);
    assign start_ok  = (state == IDLE) & start;

    // Frame start is taken only on a true rise seen while armed, so a
    // frame already in flight at arm time is skipped entirely.
    assign arm_go = (state == ARM) & ~stop & fval_rise;

    assign grey_en    = in_act & in_fval & pix & in_range;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (fval_rise) begin
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fval_fall) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (cont_r & ~stop_pending & ~stop) begin
                    state_nx = ARM;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fval_d <= 1'b0;
            lval_d <= 1'b0;
        end else begin
            fval_d <= in_fval;
            lval_d <= in_lval;
        end
    end

    // Run control: continuous flag and deferred stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_r       <= 1'b0;
            stop_pending <= 1'b0;
        end else if (start_ok) begin
            cont_r       <= cont;
            stop_pending <= 1'b0;
        end else if (stop && (state == ACTIVE || state == DONE)) begin
            stop_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (start_ok) begin
            ovf_err <= 1'b0;
        end else if (in_act & in_fval & pix & ~in_range) begin
            ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grey_mode <= 1'b0;
        end else if (arm_go) begin
            grey_mode <= grey_mode_req;
        end
    end

    // x counts every accepted-or-dropped pixel and restarts per line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
        end else if (arm_go || lval_fall) begin
            x <= '0;
        end else if (in_act && pix && x != C_MAX) begin
            x <= x + 1'b1;
        end
    end

    // Empty lines (lval without any dval) do not advance y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_has_dval <= 1'b0;
        end else if (arm_go || lval_fall) begin
            line_has_dval <= 1'b0;
        end else if (in_act && pix) begin
            line_has_dval <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (arm_go) begin
            y <= '0;
        end else if (in_act && lval_fall && line_has_dval && y != C_MAX) begin
            y <= y + 1'b1;
        end
    end

    // One-cycle output stage aligned with the converter's register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dval <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
        end else begin
            out_dval <= grey_en;
            if (grey_en) begin
                out_x <= x;
                out_y <= y;
            end
        end
    end

`ifdef GREY_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'h0000;
        end else if (state == DONE) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
